lsu_bus_master: RTL and testbench
=================================

Name: lsu_bus_master

Overview:
- Load/store initiator that drives the word-wide memory bus (rd_en/wr_en/addr/data/ack) on behalf of the datapath.
- Accepts byte/halfword/word loads and stores from the core, issues word-aligned bus cycles and waits for ack.
- Performs sign/zero extension on loads and read-modify-write for sub-word stores, because the memory writes whole words only.
- Sits between the datapath execute/mem stage and the data memory.

Parameters:
TIMEOUT_CYCLES, 16, ack wait limit in cycles; used only when LSU_TIMEOUT_EN is defined.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid_i  input  1  core request valid
req_ready_o  output  1  LSU can accept a request (high only in IDLE)
req_we_i  input  1  1=store, 0=load
req_size_i  input  2  0=byte, 1=half, 2=word; 3 treated as word
req_unsigned_i  input  1  zero-extend loads when 1
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data, right-aligned
resp_valid_o  output  1  one-cycle completion pulse
resp_rdata_o  output  32  extended load data; 0 for stores/errors
resp_err_o  output  1  misaligned access or timeout, valid with resp_valid_o
mem_rd_en_o  output  1  bus read enable
mem_wr_en_o  output  1  bus write enable
mem_addr_o  output  32  bus address, always {addr[31:2],2'b00}
mem_wdata_o  output  32  bus write data
mem_rdata_i  input  32  bus read data (combinational from memory)
mem_ack_i  input  1  bus acknowledge

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready_o=1, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_rd_en_o=0, mem_wr_en_o=0, mem_addr_o=0, mem_wdata_o=0. Reset mid-transaction drops enables immediately and produces no response.
- States: IDLE, READ, WRITE, RESP.
- IDLE: on req_valid_i&&req_ready_o, latch we/size/unsigned/addr/wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): go to RESP with err=1, no bus cycle.
  - Load or sub-word store: go to READ. Word store: go to WRITE, wdata=req_wdata_i.
- READ: mem_rd_en_o=1, mem_wr_en_o=0. On mem_ack_i, capture mem_rdata_i.
  - Load: extract lane, go to RESP.
  - Sub-word store: merge into captured word, go to WRITE.
- WRITE: mem_wr_en_o=1, mem_rd_en_o=0, mem_wdata_o=merged/full word. On mem_ack_i go to RESP.
- RESP: resp_valid_o=1 for exactly one cycle; go to IDLE.
- Bus rules:
  - mem_rd_en_o and mem_wr_en_o are never high together.
  - Addr, data and enables are held stable until ack.
  - Enables are low in IDLE and RESP.
- Lanes are little-endian. A byte at offset k occupies bits [8k+7:8k]; a half at offset 2h occupies bits [16h+15:16h].
- Loads: sign-extend from the lane MSB unless req_unsigned_i=1.
- Stores: replace only the addressed lane with wdata[7:0] or wdata[15:0]; the other bytes come from the READ data.
- Latency with ack tied high (request accepted at cycle 0, resp_valid_o at cycle N): load N=2; word store N=2; sub-word store N=3; misaligned N=1. Next accept at N+1.
- resp_rdata_o and resp_err_o are registered and hold until the next RESP.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: a counter clears on entering READ/WRITE and increments each cycle without ack. When it reaches TIMEOUT_CYCLES with no ack: drop enables, go to RESP with resp_err_o=1, resp_rdata_o=0, no further bus cycle.
- Undefined: the LSU waits for ack indefinitely and no counter logic exists.

Test Plan:
- Memory word 0x10 = 0x8899AABB, ack=1; load byte signed addr 0x11 -> resp at cycle 2, rdata=0xFFFFFFAA, err=0; same with unsigned -> 0x000000AA.
- Load half signed addr 0x12 -> 0xFFFF8899; load word addr 0x10 -> 0x8899AABB.
- Store byte 0x5C to addr 0x13 over 0x8899AABB -> one read then one write, memory=0x5C99AABB, resp at cycle 3; rd/wr never high together.
- Word store 0xDEADBEEF to 0x20 -> single write cycle, resp at cycle 2; half load at 0x21 -> err=1 at cycle 1, no enables asserted.
- Ack delayed 5 cycles -> enables/addr held for 5 cycles, correct data returned; rst_n pulsed low during the wait -> enables drop at once, no resp_valid_o, req_ready_o=1.
- With LSU_TIMEOUT_EN and ack stuck low -> resp_err_o=1, rdata=0 after 16 wait cycles; without the macro -> no response.

Source files
------------

// File: rtl/lsu_bus_master_if.sv
// lsu_bus_master_if: core load/store request/response channel plus the
// word-wide memory bus. The master modport is the LSU's view; the slave
// modport is the surrounding core + memory.
interface lsu_bus_master_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_rd_en_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, mem_rdata_i, mem_ack_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, mem_rdata_i, mem_ack_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: byte/half/word load-store initiator on a word-only bus.
// Loads extract and sign/zero-extend the addressed lane; sub-word stores do
// a read-modify-write of the containing word.
// Optional build macro LSU_TIMEOUT_EN: abort a bus cycle that sees no ack
// for TIMEOUT_CYCLES cycles and report it as an error response.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_bus_master_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] wdata_q, addr_q, mem_wdata_q, resp_rdata_q;
  logic        resp_err_q;
  logic        accept, misaligned, is_word_req, timeout;
  logic [31:0] lane_word, load_data, lane_mask, store_lanes, merged;

  assign accept      = bus.req_valid_i && (state_q == S_IDLE);
  assign is_word_req = bus.req_size_i[1];
  assign misaligned  = is_word_req ? (bus.req_addr_i[1:0] != 2'b00)
                                   : ((bus.req_size_i == 2'd1) && bus.req_addr_i[0]);

  // Load path: move the addressed lane to bit 0, then extend it.
  always_comb begin
    lane_word = bus.mem_rdata_i >> {off_q, 3'b000};
    load_data = lane_word;
    case (size_q)
      2'd0:    load_data = uns_q ? {24'h0, lane_word[7:0]}
                                 : {{24{lane_word[7]}}, lane_word[7:0]};
      2'd1:    load_data = uns_q ? {16'h0, lane_word[15:0]}
                                 : {{16{lane_word[15]}}, lane_word[15:0]};
      default: load_data = lane_word;
    endcase
  end

  // Store path: overlay the addressed lane of the store data onto the read word.
  always_comb begin
    lane_mask   = ((size_q == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << {off_q, 3'b000};
    store_lanes = wdata_q << {off_q, 3'b000};
    merged      = (bus.mem_rdata_i & ~lane_mask) | (store_lanes & lane_mask);
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             in_bus_cycle;

  assign in_bus_cycle = (state_q == S_READ) || (state_q == S_WRITE);
  assign timeout      = in_bus_cycle && !bus.mem_ack_i &&
                        (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count ack-less cycles of the current bus cycle; restart on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               wait_cnt_q <= '0;
    else if (state_d != state_q)              wait_cnt_q <= '0;
    else if (in_bus_cycle && !bus.mem_ack_i)  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
  end
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: word stores skip the read; sub-word stores read then write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (misaligned)                         state_d = S_RESP;
          else if (bus.req_we_i && is_word_req)   state_d = S_WRITE;
          else                                    state_d = S_READ;
        end
      end
      S_READ: begin
        if (bus.mem_ack_i) state_d = we_q ? S_WRITE : S_RESP;
        else if (timeout)  state_d = S_RESP;
      end
      S_WRITE: begin
        if (bus.mem_ack_i || timeout) state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, bus address/data and registered response payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      addr_q       <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we_i;
            size_q  <= bus.req_size_i;
            uns_q   <= bus.req_unsigned_i;
            off_q   <= bus.req_addr_i[1:0];
            wdata_q <= bus.req_wdata_i;
            addr_q  <= {bus.req_addr_i[31:2], 2'b00};
            if (misaligned) begin
              resp_rdata_q <= '0;
              resp_err_q   <= 1'b1;
            end else if (bus.req_we_i && is_word_req) begin
              mem_wdata_q <= bus.req_wdata_i;
            end
          end
        end
        S_READ: begin
          if (bus.mem_ack_i) begin
            if (we_q) begin
              mem_wdata_q <= merged;
            end else begin
              resp_rdata_q <= load_data;
              resp_err_q   <= 1'b0;
            end
          end else if (timeout) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
          end
        end
        S_WRITE: begin
          if (bus.mem_ack_i) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end else if (timeout) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o  = (state_q == S_IDLE);
  assign bus.resp_valid_o = (state_q == S_RESP);
  assign bus.resp_rdata_o = resp_rdata_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.mem_rd_en_o  = (state_q == S_READ);
  assign bus.mem_wr_en_o  = (state_q == S_WRITE);
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: directed and randomized load/store traffic against a
// behavioural memory with programmable ack delay and a byte-level model.
module tb_lsu_bus_master;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_bus_master_if bus ();
  lsu_bus_master #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;

  // Memory slave: 64 words, ack after ack_delay wait cycles.
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  int ack_delay = 0;
  bit ack_stuck = 1'b0;
  int wait_cnt  = 0;

  assign bus.mem_rdata_i = mem[bus.mem_addr_o[7:2]];
  assign bus.mem_ack_i   = (bus.mem_rd_en_o || bus.mem_wr_en_o) && !ack_stuck &&
                           (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    if (bus.mem_ack_i || !(bus.mem_rd_en_o || bus.mem_wr_en_o)) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (bus.mem_wr_en_o && bus.mem_ack_i) mem[bus.mem_addr_o[7:2]] = bus.mem_wdata_o;
  end

  // Bus monitor counters.
  int rd_cnt = 0, wr_cnt = 0, en_hi_cnt = 0, resp_cnt = 0, overlap_cnt = 0, hold_viol = 0;
  bit pend = 1'b0;
  logic p_rd, p_wr;
  logic [31:0] p_addr, p_wdata;

  always @(negedge clk) begin
    if (bus.mem_rd_en_o && bus.mem_wr_en_o) overlap_cnt++;
    if (bus.mem_rd_en_o || bus.mem_wr_en_o) en_hi_cnt++;
    if (bus.mem_rd_en_o && bus.mem_ack_i) rd_cnt++;
    if (bus.mem_wr_en_o && bus.mem_ack_i) wr_cnt++;
    if (bus.resp_valid_o) resp_cnt++;
    if (pend && (bus.mem_rd_en_o !== p_rd || bus.mem_wr_en_o !== p_wr ||
                 bus.mem_addr_o !== p_addr || (p_wr && bus.mem_wdata_o !== p_wdata)))
      hold_viol++;
    pend    = (bus.mem_rd_en_o || bus.mem_wr_en_o) && !bus.mem_ack_i && rst_n;
    p_rd    = bus.mem_rd_en_o;
    p_wr    = bus.mem_wr_en_o;
    p_addr  = bus.mem_addr_o;
    p_wdata = bus.mem_wdata_o;
  end

  always @(negedge rst_n) pend = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model.
  function automatic bit ref_misaligned(input int size, input logic [31:0] addr);
    if (size == 1) return addr[0];
    if (size >= 2) return addr[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input int size, input bit uns);
    longint v;
    int off;
    off = int'(addr[1:0]);
    if (size == 0) begin
      v = (longint'(word) >> (8 * off)) & 255;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = (longint'(word) >> (8 * off)) & 65535;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(word);
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] addr,
                                            input int size, input logic [31:0] wdata);
    logic [7:0] b [4];
    int off;
    if (size >= 2) return wdata;
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    off = int'(addr[1:0]);
    b[off] = wdata[7:0];
    if (size == 1) b[off + 1] = wdata[15:8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Drive one request (call at a negedge); returns latency in cycles from accept.
  task automatic issue(input logic we, input int size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output int waited);
    waited = 0;
    while (!bus.req_ready_o && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = 2'(size);
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wdata;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid_o && lat < 100);
    if (!bus.resp_valid_o) lat = -1;
    rdata = bus.resp_rdata_o;
    err   = bus.resp_err_o;
  endtask

  task automatic test_reset();
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'd0;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.req_ready_o, bus.resp_valid_o, bus.resp_err_o, bus.mem_rd_en_o, bus.mem_wr_en_o} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 10000",
               {bus.req_ready_o, bus.resp_valid_o, bus.resp_err_o, bus.mem_rd_en_o, bus.mem_wr_en_o});
    end
    vectors++;
    if ({bus.resp_rdata_o, bus.mem_addr_o, bus.mem_wdata_o} !== 96'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%h/%h expected all 0",
               bus.resp_rdata_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_extend();
    logic [31:0] addrs [6] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10, 32'h10};
    int          sizes [6] = '{0, 0, 1, 1, 2, 0};
    bit          unss  [6] = '{0, 1, 0, 1, 0, 0};
    logic [31:0] exps  [6] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899,
                               32'h00008899, 32'h8899AABB, 32'hFFFFFFBB};
    int lat, waited;
    logic [31:0] rdata;
    logic err;
    ack_delay = 0;
    mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, sizes[i], unss[i], addrs[i], 32'h0, lat, rdata, err, waited);
      vectors++;
      if (lat != 2 || rdata !== exps[i] || err !== 1'b0) begin
        miscompares++;
        $display("FAIL load_%0d: got lat=%0d rdata=%h err=%b expected lat=2 rdata=%h err=0",
                 i, lat, rdata, err, exps[i]);
      end
    end
  endtask

  task automatic test_subword_store();
    int lat, waited, r0, w0;
    logic [31:0] rdata;
    logic err;
    ack_delay = 0;
    mem[4] = 32'h8899AABB;
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 0, 1'b0, 32'h13, 32'h1234565C, lat, rdata, err, waited);
    #1;
    vectors++;
    if (lat != 3 || mem[4] !== 32'h5C99AABB || err !== 1'b0 || rdata !== 32'h0 ||
        rd_cnt - r0 != 1 || wr_cnt - w0 != 1) begin
      miscompares++;
      $display("FAIL store_byte: got lat=%0d mem=%h err=%b rdata=%h rd=%0d wr=%0d expected 3 5C99AABB 0 0 1 1",
               lat, mem[4], err, rdata, rd_cnt - r0, wr_cnt - w0);
    end
    issue(1'b1, 1, 1'b0, 32'h10, 32'hA5A5BEEF, lat, rdata, err, waited);
    #1;
    vectors++;
    if (lat != 3 || mem[4] !== 32'h5C99BEEF) begin
      miscompares++;
      $display("FAIL store_half: got lat=%0d mem=%h expected 3 5C99BEEF", lat, mem[4]);
    end
    vectors++;
    if (overlap_cnt != 0) begin
      miscompares++;
      $display("FAIL rd_wr_overlap: got %0d expected 0", overlap_cnt);
    end
    ref_mem[4] = 32'h5C99BEEF;
  endtask

  task automatic test_word_store_misaligned();
    int lat, waited, r0, w0, e0;
    logic [31:0] rdata;
    logic err;
    ack_delay = 0;
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 2, 1'b0, 32'h20, 32'hDEADBEEF, lat, rdata, err, waited);
    #1;
    vectors++;
    if (lat != 2 || mem[8] !== 32'hDEADBEEF || rd_cnt - r0 != 0 || wr_cnt - w0 != 1) begin
      miscompares++;
      $display("FAIL word_store: got lat=%0d mem=%h rd=%0d wr=%0d expected 2 DEADBEEF 0 1",
               lat, mem[8], rd_cnt - r0, wr_cnt - w0);
    end
    ref_mem[8] = 32'hDEADBEEF;
    e0 = en_hi_cnt;
    issue(1'b0, 1, 1'b0, 32'h21, 32'h0, lat, rdata, err, waited);
    #1;
    vectors++;
    if (lat != 1 || err !== 1'b1 || rdata !== 32'h0 || en_hi_cnt != e0) begin
      miscompares++;
      $display("FAIL misaligned_half: got lat=%0d err=%b rdata=%h en_cycles=%0d expected 1 1 0 0",
               lat, err, rdata, en_hi_cnt - e0);
    end
    issue(1'b1, 3, 1'b0, 32'h22, 32'h11111111, lat, rdata, err, waited);
    #1;
    vectors++;
    if (lat != 1 || err !== 1'b1 || en_hi_cnt != e0 || mem[8] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL misaligned_word: got lat=%0d err=%b en_cycles=%0d mem=%h expected 1 1 0 DEADBEEF",
               lat, err, en_hi_cnt - e0, mem[8]);
    end
  endtask

  task automatic test_back_to_back();
    int lat, waited;
    logic [31:0] rdata;
    logic err;
    ack_delay = 0;
    issue(1'b0, 2, 1'b0, 32'h20, 32'h0, lat, rdata, err, waited);
    issue(1'b0, 0, 1'b1, 32'h23, 32'h0, lat, rdata, err, waited);
    vectors++;
    if (waited != 1 || lat != 2 || rdata !== 32'h000000DE || err !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back: got waited=%0d lat=%0d rdata=%h err=%b expected 1 2 000000DE 0",
               waited, lat, rdata, err);
    end
    @(negedge clk);
    vectors++;
    if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL resp_one_cycle: got valid=%b ready=%b expected 0 1",
               bus.resp_valid_o, bus.req_ready_o);
    end
  endtask

  task automatic test_ack_delay();
    int lat, waited, e0;
    logic [31:0] rdata;
    logic err;
    ack_delay = 5;
    e0 = en_hi_cnt;
    issue(1'b0, 2, 1'b0, 32'h10, 32'h0, lat, rdata, err, waited);
    #1;
    vectors++;
    if (lat != 7 || rdata !== ref_mem[4] || en_hi_cnt - e0 != 6) begin
      miscompares++;
      $display("FAIL ack_delay_load: got lat=%0d rdata=%h en_cycles=%0d expected 7 %h 6",
               lat, rdata, en_hi_cnt - e0, ref_mem[4]);
    end
    issue(1'b1, 0, 1'b0, 32'h21, 32'h00000077, lat, rdata, err, waited);
    #1;
    ref_mem[8] = ref_store(ref_mem[8], 32'h21, 0, 32'h77);
    vectors++;
    if (lat != 13 || mem[8] !== ref_mem[8]) begin
      miscompares++;
      $display("FAIL ack_delay_store: got lat=%0d mem=%h expected 13 %h", lat, mem[8], ref_mem[8]);
    end
    vectors++;
    if (hold_viol != 0) begin
      miscompares++;
      $display("FAIL bus_hold: got %0d violations expected 0", hold_viol);
    end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid();
    int c0;
    ack_delay = 10;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'd2;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h10;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.mem_rd_en_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_waiting: got rd_en=%b expected 1", bus.mem_rd_en_o);
    end
    c0 = resp_cnt;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.mem_rd_en_o, bus.mem_wr_en_o, bus.req_ready_o, bus.resp_valid_o} !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_mid_drop: got %b expected 0010",
               {bus.mem_rd_en_o, bus.mem_wr_en_o, bus.req_ready_o, bus.resp_valid_o});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    vectors++;
    if (resp_cnt != c0 || bus.req_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_noresp: got resp=%0d ready=%b expected 0 1",
               resp_cnt - c0, bus.req_ready_o);
    end
    ack_delay = 0;
  endtask

  task automatic test_timeout();
`ifdef LSU_TIMEOUT_EN
    int lat, waited, r0, e0;
    logic [31:0] rdata;
    logic err;
    ack_stuck = 1'b1;
    r0 = rd_cnt; e0 = en_hi_cnt;
    issue(1'b0, 2, 1'b0, 32'h10, 32'h0, lat, rdata, err, waited);
    #1;
    vectors++;
    if (lat != 17 || err !== 1'b1 || rdata !== 32'h0 || rd_cnt != r0 || en_hi_cnt - e0 != 16) begin
      miscompares++;
      $display("FAIL timeout: got lat=%0d err=%b rdata=%h acks=%0d en_cycles=%0d expected 17 1 0 0 16",
               lat, err, rdata, rd_cnt - r0, en_hi_cnt - e0);
    end
    ack_stuck = 1'b0;
    issue(1'b0, 2, 1'b0, 32'h10, 32'h0, lat, rdata, err, waited);
    vectors++;
    if (lat != 2 || err !== 1'b0 || rdata !== ref_mem[4]) begin
      miscompares++;
      $display("FAIL timeout_recover: got lat=%0d err=%b rdata=%h expected 2 0 %h",
               lat, err, rdata, ref_mem[4]);
    end
`else
    int c0;
    ack_stuck = 1'b1;
    c0 = resp_cnt;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'd2;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h10;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    vectors++;
    if (resp_cnt != c0 || bus.mem_rd_en_o !== 1'b1) begin
      miscompares++;
      $display("FAIL no_timeout_wait: got resp=%0d rd_en=%b expected 0 1",
               resp_cnt - c0, bus.mem_rd_en_o);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_stuck = 1'b0;
    @(negedge clk);
`endif
  endtask

  task automatic test_random();
    int lat, waited, r0, w0, size, d, exp_lat, exp_rd, exp_wr, idx;
    logic [31:0] rdata, addr, wdata, exp_rdata;
    logic err, we, uns;
    bit mis;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    for (int n = 0; n < 60; n++) begin
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = $urandom_range(0, 3);
      addr  = 32'($urandom_range(0, 255));
      wdata = $urandom;
      d     = $urandom_range(0, 3);
      ack_delay = d;
      idx = int'(addr[7:2]);
      mis = ref_misaligned(size, addr);
      exp_rdata = '0;
      if (mis) begin
        exp_lat = 1; exp_rd = 0; exp_wr = 0;
      end else if (!we) begin
        exp_lat = d + 2; exp_rd = 1; exp_wr = 0;
        exp_rdata = ref_load(ref_mem[idx], addr, size, uns);
      end else if (size >= 2) begin
        exp_lat = d + 2; exp_rd = 0; exp_wr = 1;
        ref_mem[idx] = ref_store(ref_mem[idx], addr, size, wdata);
      end else begin
        exp_lat = 2 * d + 3; exp_rd = 1; exp_wr = 1;
        ref_mem[idx] = ref_store(ref_mem[idx], addr, size, wdata);
      end
      r0 = rd_cnt; w0 = wr_cnt;
      issue(we, size, uns, addr, wdata, lat, rdata, err, waited);
      #1;
      vectors++;
      if (lat != exp_lat || rdata !== exp_rdata || err !== mis) begin
        miscompares++;
        $display("FAIL rand_%0d_resp: we=%b size=%0d uns=%b addr=%h got lat=%0d rdata=%h err=%b expected %0d %h %b",
                 n, we, size, uns, addr, lat, rdata, err, exp_lat, exp_rdata, mis);
      end
      vectors++;
      if (rd_cnt - r0 != exp_rd || wr_cnt - w0 != exp_wr || mem[idx] !== ref_mem[idx]) begin
        miscompares++;
        $display("FAIL rand_%0d_bus: got rd=%0d wr=%0d mem=%h expected %0d %0d %h",
                 n, rd_cnt - r0, wr_cnt - w0, mem[idx], exp_rd, exp_wr, ref_mem[idx]);
      end
    end
    vectors++;
    if (overlap_cnt != 0 || hold_viol != 0) begin
      miscompares++;
      $display("FAIL rand_bus_rules: got overlap=%0d hold=%0d expected 0 0", overlap_cnt, hold_viol);
    end
    ack_delay = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_load_extend();
    test_subword_store();
    test_word_store_misaligned();
    test_back_to_back();
    test_ack_delay();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
